// File: rtl/rayforge_pkg.sv
// Shared types for the ray-hit reduction path.
// Provides the per-object hit record, default widths and the "no object" index.
package rayforge_pkg;

  localparam int unsigned T_W   = 12;
  localparam int unsigned IDX_W = 8;

  localparam logic [IDX_W-1:0] IDX_NONE = 8'hFF;

  // One object's intersection record; hit doubles as "record is valid".
  typedef struct packed {
    logic                    hit;
    logic [IDX_W-1:0]        idx;
    logic signed [T_W-1:0]   t;
    logic [7:0]              r;
    logic [7:0]              g;
    logic [7:0]              b;
    logic signed [T_W-1:0]   refl;
  } hit_rec_t;

endpackage

// File: rtl/hit_select.sv
// Combinational nearest-hit merge.
// Ports: best     - currently held record (hit=0 means empty)
//        cand     - incoming candidate (hit=0 means no intersection / no beat)
//        t_min    - smallest accepted distance (self-intersection guard)
//        merged_c - candidate if it qualifies and is strictly nearer, else best
module hit_select
  import rayforge_pkg::*;
(
  input  hit_rec_t                best,
  input  hit_rec_t                cand,
  input  logic signed [T_W-1:0]   t_min,
  output hit_rec_t                merged_c
);

  logic qual_c;
  logic take_c;

  // Strictly-less keeps the earlier object on equal distance.
  assign qual_c   = cand.hit && ($signed(cand.t) >= t_min);
  assign take_c   = qual_c && (!best.hit || ($signed(cand.t) < $signed(best.t)));
  assign merged_c = take_c ? cand : best;

endmodule

// File: rtl/hit_reducer.sv
// Per-pixel nearest-hit reducer.
// Consumes one candidate beat per object, tracks the nearest qualifying hit
// and publishes one result per pixel (on the in_last beat) via ready/valid.
// Ports: clk, rst_n (async, active-low)
//        in_valid/in_last/in_idx/in_hit/in_t/in_color*/in_refl - candidate stream
//        res_valid/res_ready - result handshake
//        res_hit/res_idx/res_t/res_color*/res_refl/res_count - result payload
//        overrun - sticky dropped-result flag, cleared by clr_err
module hit_reducer
  import rayforge_pkg::*;
#(
  parameter logic signed [T_W-1:0] T_MIN = 12'sd1,
  parameter logic [7:0]            BG_R  = 8'd0,
  parameter logic [7:0]            BG_G  = 8'd0,
  parameter logic [7:0]            BG_B  = 8'd32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic [IDX_W-1:0]        in_idx,
  input  logic                    in_hit,
  input  logic signed [T_W-1:0]   in_t,
  input  logic [7:0]              in_colorR,
  input  logic [7:0]              in_colorG,
  input  logic [7:0]              in_colorB,
  input  logic signed [T_W-1:0]   in_refl,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    res_hit,
  output logic [IDX_W-1:0]        res_idx,
  output logic signed [T_W-1:0]   res_t,
  output logic [7:0]              res_colorR,
  output logic [7:0]              res_colorG,
  output logic [7:0]              res_colorB,
  output logic signed [T_W-1:0]   res_refl,
  output logic [IDX_W-1:0]        res_count,
  output logic                    overrun,
  input  logic                    clr_err
);

  // Empty accumulator already holds the no-hit result, so a pixel with no
  // qualifying candidate publishes it without extra muxing.
  localparam hit_rec_t BEST_EMPTY = '{hit: 1'b0, idx: IDX_NONE, t: '0,
                                      r: BG_R, g: BG_G, b: BG_B, refl: '0};
  localparam hit_rec_t RES_RST    = '{hit: 1'b0, idx: IDX_NONE, t: '0,
                                      r: 8'd0, g: 8'd0, b: 8'd0, refl: '0};

  hit_rec_t         best_q, best_d;
  logic [IDX_W-1:0] count_q, count_d;
  hit_rec_t         res_q, res_d;
  logic [IDX_W-1:0] res_count_q, res_count_d;
  logic             res_valid_q, res_valid_d;
  logic             overrun_q, overrun_d;

  hit_rec_t         cand_c;
  hit_rec_t         merged_c;
  logic [IDX_W-1:0] count_inc_c;
  logic             load_ok_c;
  logic             overrun_set_c;

  // Candidate record; hit is gated by in_valid so idle cycles never qualify.
  always_comb begin
    cand_c      = RES_RST;
    cand_c.hit  = in_valid && in_hit;
    cand_c.idx  = in_idx;
    cand_c.t    = in_t;
    cand_c.r    = in_colorR;
    cand_c.g    = in_colorG;
    cand_c.b    = in_colorB;
    cand_c.refl = in_refl;
  end

  // Shared merge for both running accumulation and the final last-beat result.
  hit_select u_hit_select (
    .best     (best_q),
    .cand     (cand_c),
    .t_min    (T_MIN),
    .merged_c (merged_c)
  );

  assign count_inc_c = (&count_q) ? count_q : count_q + IDX_W'(1);
  assign load_ok_c   = !res_valid_q || res_ready;

  // Accumulate, publish on last beat, handle drain and overrun.
  always_comb begin
    best_d        = best_q;
    count_d       = count_q;
    res_d         = res_q;
    res_count_d   = res_count_q;
    res_valid_d   = res_valid_q;
    overrun_set_c = 1'b0;

    if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end

    if (in_valid) begin
      best_d  = merged_c;
      count_d = count_inc_c;
      if (in_last) begin
        best_d  = BEST_EMPTY;
        count_d = '0;
        if (load_ok_c) begin
          res_d       = merged_c;
          res_count_d = count_inc_c;
          res_valid_d = 1'b1;
        end else begin
          overrun_set_c = 1'b1;
        end
      end
    end

    // Set beats clear when both happen together.
    if (overrun_set_c) begin
      overrun_d = 1'b1;
    end else if (clr_err) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_q      <= BEST_EMPTY;
      count_q     <= '0;
      res_q       <= RES_RST;
      res_count_q <= '0;
      res_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      best_q      <= best_d;
      count_q     <= count_d;
      res_q       <= res_d;
      res_count_q <= res_count_d;
      res_valid_q <= res_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign res_valid  = res_valid_q;
  assign res_hit    = res_q.hit;
  assign res_idx    = res_q.idx;
  assign res_t      = res_q.t;
  assign res_colorR = res_q.r;
  assign res_colorG = res_q.g;
  assign res_colorB = res_q.b;
  assign res_refl   = res_q.refl;
  assign res_count  = res_count_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_hit_reducer.sv
// Self-checking bench for hit_reducer: directed scenarios plus randomized
// pixels checked against a nearest-hit reference model.
module tb_hit_reducer;
  import rayforge_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid, in_last, in_hit;
  logic [IDX_W-1:0]      in_idx;
  logic signed [T_W-1:0] in_t, in_refl;
  logic [7:0]            in_colorR, in_colorG, in_colorB;
  logic                  res_valid, res_ready, res_hit;
  logic [IDX_W-1:0]      res_idx, res_count;
  logic signed [T_W-1:0] res_t, res_refl;
  logic [7:0]            res_colorR, res_colorG, res_colorB;
  logic                  overrun, clr_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit         hit;
    int         idx;
    int         t;
    logic [7:0] r, g, b;
    int         refl;
  } beat_t;

  beat_t pix[$];

  localparam logic [64:0] RST_VEC = {1'b0, 8'hFF, 12'd0, 8'd0, 8'd0, 8'd0, 12'd0, 8'd0};

  always #5 clk = ~clk;

  hit_reducer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_last(in_last), .in_idx(in_idx), .in_hit(in_hit),
    .in_t(in_t), .in_colorR(in_colorR), .in_colorG(in_colorG), .in_colorB(in_colorB),
    .in_refl(in_refl),
    .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit), .res_idx(res_idx),
    .res_t(res_t), .res_colorR(res_colorR), .res_colorG(res_colorG), .res_colorB(res_colorB),
    .res_refl(res_refl), .res_count(res_count), .overrun(overrun), .clr_err(clr_err)
  );

  // Reference: the smallest qualifying distance, first object holding it wins.
  function automatic logic [64:0] model();
    int   best_t = 32'h7fffffff;
    int   bi     = -1;
    int   cnt    = (pix.size() > 255) ? 255 : pix.size();
    foreach (pix[i]) if (pix[i].hit && pix[i].t >= 1 && pix[i].t < best_t) best_t = pix[i].t;
    foreach (pix[i]) if (bi < 0 && pix[i].hit && pix[i].t == best_t) bi = i;
    if (bi < 0)
      return {1'b0, 8'hFF, 12'd0, 8'd0, 8'd0, 8'd32, 12'd0, 8'(cnt)};
    return {1'b1, 8'(pix[bi].idx), 12'(pix[bi].t), pix[bi].r, pix[bi].g, pix[bi].b,
            12'(pix[bi].refl), 8'(cnt)};
  endfunction

  function automatic logic [64:0] dut_vec();
    return {res_hit, res_idx, res_t, res_colorR, res_colorG, res_colorB, res_refl, res_count};
  endfunction

  function automatic beat_t mk(int idx, bit hit, int t);
    beat_t b;
    b.idx = idx; b.hit = hit; b.t = t;
    b.r = 8'($urandom_range(0, 255));
    b.g = 8'($urandom_range(0, 255));
    b.b = 8'($urandom_range(0, 255));
    b.refl = int'($urandom_range(0, 4095)) - 2048;
    return b;
  endfunction

  task automatic send_beat(input int i, input bit last);
    in_valid  = 1'b1;
    in_last   = last;
    in_idx    = 8'(pix[i].idx);
    in_hit    = pix[i].hit;
    in_t      = 12'(pix[i].t);
    in_colorR = pix[i].r;
    in_colorG = pix[i].g;
    in_colorB = pix[i].b;
    in_refl   = 12'(pix[i].refl);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
  endtask

  task automatic send_pixel();
    foreach (pix[i]) send_beat(i, i == pix.size() - 1);
  endtask

  // Idle cycle; a stray in_last without in_valid must be ignored.
  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'($urandom_range(0, 1));
    in_hit   = 1'($urandom_range(0, 1));
    in_t     = 12'sd2;
    @(posedge clk); #1;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 0; in_last = 0; in_idx = 0; in_hit = 0; in_t = 0;
    in_colorR = 0; in_colorG = 0; in_colorB = 0; in_refl = 0; res_ready = 1; clr_err = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (res_valid !== 1'b0 || overrun !== 1'b0) begin
      failures++; $display("FAIL reset_flags got valid=%b overrun=%b want 0 0", res_valid, overrun);
    end
    checks++;
    if (dut_vec() !== RST_VEC) begin
      failures++; $display("FAIL reset_payload got %h want %h", dut_vec(), RST_VEC);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int ts[4] = '{40, 12, 25, 12};
    logic [64:0] exp_v;
    pix = {};
    for (int i = 0; i < 4; i++) pix.push_back(mk(i, 1, ts[i]));
    exp_v = model();
    send_pixel();
    checks++;
    if (res_valid !== 1'b1 || res_idx !== 8'd1 || res_t !== 12'sd12 || res_count !== 8'd4) begin
      failures++;
      $display("FAIL basic_fields got v=%b idx=%0d t=%0d cnt=%0d want 1 1 12 4",
               res_valid, res_idx, res_t, res_count);
    end
    checks++;
    if (dut_vec() !== exp_v) begin
      failures++; $display("FAIL basic_payload got %h want %h", dut_vec(), exp_v);
    end
    idle();
    checks++;
    if (res_valid !== 1'b0) begin
      failures++; $display("FAIL basic_drain got valid=%b want 0", res_valid);
    end
  endtask

  task automatic test_no_hit();
    logic [64:0] want = {1'b0, 8'hFF, 12'd0, 8'd0, 8'd0, 8'd32, 12'd0, 8'd3};
    pix = {};
    for (int i = 0; i < 3; i++) pix.push_back(mk(i + 7, 0, 10 + i));
    send_pixel();
    checks++;
    if (res_valid !== 1'b1 || dut_vec() !== want) begin
      failures++; $display("FAIL no_hit got v=%b %h want 1 %h", res_valid, dut_vec(), want);
    end
    idle();
  endtask

  task automatic test_tmin();
    pix = {};
    pix.push_back(mk(0, 1, 0));
    pix.push_back(mk(1, 1, -5));
    pix.push_back(mk(2, 1, 30));
    send_pixel();
    checks++;
    if (res_idx !== 8'd2 || res_t !== 12'sd30 || res_hit !== 1'b1 || dut_vec() !== model()) begin
      failures++; $display("FAIL tmin got %h want %h (idx 2)", dut_vec(), model());
    end
    idle();
  endtask

  task automatic test_overrun();
    logic [64:0] exp_a;
    res_ready = 1'b0;
    pix = {}; pix.push_back(mk(3, 1, 15)); pix.push_back(mk(4, 1, 8));
    exp_a = model();
    send_pixel();
    pix = {}; pix.push_back(mk(9, 1, 2)); pix.push_back(mk(10, 0, 5));
    send_pixel();
    checks++;
    if (res_valid !== 1'b1 || dut_vec() !== exp_a || overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_hold got v=%b ovr=%b %h want 1 1 %h", res_valid, overrun, dut_vec(), exp_a);
    end
    clr_err = 1'b1; idle(); clr_err = 1'b0;
    checks++;
    if (overrun !== 1'b0 || dut_vec() !== exp_a || res_valid !== 1'b1) begin
      failures++; $display("FAIL overrun_clear got ovr=%b %h want 0 %h", overrun, dut_vec(), exp_a);
    end
    pix = {}; pix.push_back(mk(11, 1, 4)); pix.push_back(mk(12, 1, 3));
    send_beat(0, 0);
    clr_err = 1'b1;
    send_beat(1, 1);
    clr_err = 1'b0;
    checks++;
    if (overrun !== 1'b1 || dut_vec() !== exp_a) begin
      failures++; $display("FAIL overrun_set_wins got ovr=%b %h want 1 %h", overrun, dut_vec(), exp_a);
    end
    clr_err = 1'b1; idle(); clr_err = 1'b0;
    res_ready = 1'b1; idle();
    checks++;
    if (res_valid !== 1'b0 || overrun !== 1'b0) begin
      failures++; $display("FAIL overrun_exit got v=%b ovr=%b want 0 0", res_valid, overrun);
    end
  endtask

  task automatic test_back_to_back();
    logic [64:0] exp_b;
    res_ready = 1'b0;
    pix = {}; pix.push_back(mk(20, 1, 50));
    send_pixel();
    pix = {}; pix.push_back(mk(21, 1, 6)); pix.push_back(mk(22, 1, 5)); pix.push_back(mk(23, 1, 5));
    exp_b = model();
    send_beat(0, 0); send_beat(1, 0);
    res_ready = 1'b1;
    send_beat(2, 1);
    checks++;
    if (res_valid !== 1'b1 || dut_vec() !== exp_b || overrun !== 1'b0) begin
      failures++;
      $display("FAIL drain_refill got v=%b ovr=%b %h want 1 0 %h", res_valid, overrun, dut_vec(), exp_b);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    pix = {};
    for (int i = 0; i < 4; i++) pix.push_back(mk(30 + i, 1, 3));
    send_beat(0, 0); send_beat(1, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b0 || dut_vec() !== RST_VEC) begin
      failures++; $display("FAIL reset_mid got v=%b %h want 0 %h", res_valid, dut_vec(), RST_VEC);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    pix = {}; pix.push_back(mk(4, 1, 20)); pix.push_back(mk(5, 1, 9));
    send_pixel();
    checks++;
    if (res_idx !== 8'd5 || res_count !== 8'd2 || dut_vec() !== model()) begin
      failures++; $display("FAIL reset_fresh got %h want %h", dut_vec(), model());
    end
    idle();
  endtask

  task automatic test_saturate();
    pix = {};
    for (int i = 0; i < 260; i++) pix.push_back(mk(i % 200, i == 100, 7));
    send_pixel();
    checks++;
    if (res_count !== 8'd255 || dut_vec() !== model()) begin
      failures++; $display("FAIL saturate got %h want %h", dut_vec(), model());
    end
    idle();
  endtask

  task automatic test_random();
    for (int p = 0; p < 40; p++) begin
      int n = $urandom_range(1, 6);
      pix = {};
      for (int i = 0; i < n; i++)
        pix.push_back(mk($urandom_range(0, 254), $urandom_range(0, 3) != 0,
                         int'($urandom_range(0, 80)) - 20));
      foreach (pix[i]) begin
        send_beat(i, i == n - 1);
        if (i != n - 1 && $urandom_range(0, 3) == 0) idle();
      end
      checks++;
      if (res_valid !== 1'b1 || dut_vec() !== model()) begin
        failures++; $display("FAIL random_pixel_%0d got v=%b %h want %h", p, res_valid, dut_vec(), model());
      end
      if ($urandom_range(0, 1) == 1) idle();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_hit();
    test_tmin();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hit_reducer.md
Name: hit_reducer

Overview:
- Receiving end of the per-object scene stream. Each beat carries one object's intersection candidate for the current pixel.
- Keeps a running nearest-hit over the scan. When the beat flagged last arrives, it publishes one per-pixel result through a ready/valid output.
- Sits between the intersection pipeline (driven by scene_streamer valid/idx/done) and the shader/framebuffer writer.

Parameters:
- T_W, 12, width of signed distance t and reflectivity.
- IDX_W, 8, object index width.
- T_MIN, 12'sd1, minimum accepted t; candidates with t < T_MIN are rejected (self-intersection guard).
- BG_R, 8'd0, background red for no-hit result.
- BG_G, 8'd0, background green.
- BG_B, 8'd32, background blue.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  candidate beat valid; no backpressure, always accepted
- in_last  in  1  final object of this pixel; qualified by in_valid (aligns with streamer done)
- in_idx  in  IDX_W  object index
- in_hit  in  1  ray intersects object
- in_t  in  T_W  signed hit distance
- in_colorR/G/B  in  8 each  object colour
- in_refl  in  T_W  signed reflectivity
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_hit  out  1  any valid hit this pixel
- res_idx  out  IDX_W  nearest object index, IDX_NONE (8'hFF) if none
- res_t  out  T_W  nearest t, 0 if none
- res_colorR/G/B  out  8 each  nearest colour, BG_* if none
- res_refl  out  T_W  nearest reflectivity, 0 if none
- res_count  out  IDX_W  beats seen this pixel, saturating at 255
- overrun  out  1  sticky: a completed pixel was dropped because the output was full
- clr_err  in  1  synchronous clear of overrun

Behaviour:
- Reset: all res_* fields 0 except res_idx = IDX_NONE; res_colorR/G/B = 0; res_valid = 0; overrun = 0; accumulator empty with count 0. Reset mid-scan discards the partial pixel.
- Accumulator state: best_valid, best record, count.
- Candidate qualifies when in_valid && in_hit && in_t >= T_MIN (signed compare).
- A qualifying candidate replaces best when !best_valid or in_t < best.t. Strictly less: on equal t the earlier (already-held) object wins.
- count increments on every in_valid beat and saturates at 255.
- Beat with in_valid && in_last:
  - Final result = merge(best, this beat), computed combinationally.
  - Loaded into the output register on that clock edge if output load is allowed; res_valid becomes 1 the next cycle (1-cycle latency from last beat).
  - The accumulator is cleared on the same edge, so the next beat starts a new pixel with no bubble.
- Output load allowed when !res_valid || res_ready (drain and refill in the same cycle).
- If the load is not allowed: the new result is dropped, the output keeps the old result, overrun is set to 1, and the accumulator is still cleared.
- No-hit result: res_hit = 0, res_idx = IDX_NONE, res_t = 0, colour = BG_*, res_refl = 0; res_count still reports beats.
- Output register holds stable while res_valid && !res_ready. res_valid drops on handshake with no new load.
- in_last without in_valid is ignored.
- clr_err clears overrun. If clr_err coincides with a new overrun event, the set wins.
- A single-beat pixel (in_valid && in_last on the first beat) is legal and yields res_count = 1.

Decomposition:
- rayforge_pkg holds:
  - hit_rec_t struct {hit, idx, t, r, g, b, refl}
  - IDX_NONE = 8'hFF
  - T_W and IDX_W defaults
- Sub-module hit_select (combinational): inputs best, candidate and T_MIN. Outputs the merged hit_rec_t. Used for both the accumulate path and the last-beat path.

Test Plan:
- 4 beats: idx 0..3, t = {40, 12, 25, 12}, all hit, last on idx 3, res_ready = 1 -> one cycle later res_valid = 1, res_idx = 1, res_t = 12, res_count = 4.
- 3 beats all in_hit = 0 -> res_hit = 0, res_idx = 8'hFF, colour = (0, 0, 32), res_count = 3.
- Candidate t = 0 and t = -5 with hits, plus idx 2 with t = 30 -> res_idx = 2; the negative and zero t values are rejected.
- res_ready held 0, two back-to-back pixels complete -> first result stays on outputs, overrun = 1. Then clr_err -> overrun = 0.
- res_ready = 1 on the same cycle a new pixel completes while res_valid = 1 -> old result drained, new result loaded, overrun stays 0.
- rst_n asserted after 2 of 4 beats, then a fresh 2-beat pixel (t = 9 at idx 5) -> result idx 5, count 2, with no residue from the aborted pixel.
